udp_rx_mux: RTL
===============

UDP_RX_MUX -- requirements
Module: udp_rx_mux

Interface
REQ-001 SHALL take parameter P_CH_NUM, default 4, number of listening UDP port channels (legal 1..8).
REQ-002 SHALL take parameter P_DEFAULT_PORT, default 16'h0808; channel k resets to port P_DEFAULT_PORT+k.
REQ-003 SHALL have these ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_port_cfg  in  16*P_CH_NUM  channel k listening port in bits [16k+15:16k].
- i_port_cfg_valid  in  1  latch i_port_cfg into the port table.
- s_axis_ip_data  in  64  IP payload beat; first beat is the UDP header.
- s_axis_ip_user  in  56  [55:40] IP payload length in bytes; other bits ignored.
- s_axis_ip_keep  in  8  byte enables, meaningful on last beat only.
- s_axis_ip_last  in  1  last beat of packet.
- s_axis_ip_valid  in  1  beat valid; no backpressure.
- m_axis_user_data  out  64  UDP payload beat.
- m_axis_user_user  out  32  [31:16] source port, [15:0] payload bytes (UDP length - 8).
- m_axis_user_chan  out  3  index of matched channel.
- m_axis_user_keep  out  8  byte enables; 8'hff except on last.
- m_axis_user_last  out  1  last payload beat.
- m_axis_user_valid  out  1  payload beat valid.
- o_drop_cnt  out  16  count of dropped packets, saturating at 16'hffff.

Function
REQ-004 SHALL implement states IDLE, PAYLOAD, DROP; IDLE on reset.
REQ-005 SHALL treat the first valid beat in IDLE as header: [63:48] src port, [47:32] dst port, [31:16] UDP length, [15:0] checksum (ignored).
REQ-006 SHALL compare dst port to every table entry in parallel; lowest matching index wins.
REQ-007 On match with last=0: go to PAYLOAD, latch channel, src port, UDP length - 8 (16-bit, wraps if UDP length < 8).
REQ-008 On no match, or header beat with last=1 (zero payload): go to DROP (or stay IDLE if last=1), increment o_drop_cnt once.
REQ-009 SHALL never output header beats; each PAYLOAD beat accepted at cycle t SHALL appear on outputs at t+2 with its data, keep (if last) and last.
REQ-010 m_axis_user_user and m_axis_user_chan SHALL be held constant for every beat of a packet.
REQ-011 PAYLOAD/DROP SHALL return to IDLE on the beat with s_axis_ip_last=1; a header in the very next cycle SHALL be parsed normally (back-to-back packets).
REQ-012 Gaps (valid=0) mid-packet SHALL produce output gaps of equal length, no state change.
REQ-013 i_port_cfg_valid SHALL update the table in one cycle; header compare in the same cycle SHALL use the old table; an in-flight packet is unaffected.
REQ-014 m_axis_user_valid SHALL be 0 in any cycle not carrying a payload beat.

Reset
REQ-015 Reset SHALL force state IDLE, table to defaults, o_drop_cnt 0, all m_axis outputs 0 except m_axis_user_keep 8'hff.
REQ-016 Reset mid-packet SHALL discard the packet; beats after release SHALL be ignored until a beat with last=1 has passed... no: first valid beat after release SHALL be treated as a header.

Configuration
REQ-017 Macro UDP_RX_LEN_CHECK_EN defined: header with UDP length != s_axis_ip_user[55:40] SHALL go to DROP and increment o_drop_cnt.
REQ-018 Macro undefined: no length check; s_axis_ip_user ignored entirely.

Verification
REQ-019 Defaults, header dst 16'h0809, 3 payload beats, last keep 8'h0f -> 3 output beats, chan 1, user {src,16'd20}, last keep 8'h0f, t+2 latency.
REQ-020 Header dst 16'h1234 (no match), 4 beats -> no output, o_drop_cnt 1.
REQ-021 Two packets back-to-back to ports 16'h0808 then 16'h080B -> chan 0 then chan 3, no bubble beyond header slot.
REQ-022 Config all channels 16'h5000 with valid same cycle as header dst 16'h5000 -> dropped; next packet to 16'h5000 -> chan 0.
REQ-023 With UDP_RX_LEN_CHECK_EN: UDP length 28, user[55:40]=36 -> dropped, o_drop_cnt +1; without macro -> delivered.
REQ-024 Assert i_rst mid-PAYLOAD -> outputs zero immediately; next packet after release delivered correctly.

Source files
------------

// File: rtl/udp_rx_mux.sv
// udp_rx_mux: parses the UDP header of each incoming IP payload, matches the
// destination port against a table of listening ports and forwards the UDP
// payload tagged with the matched channel, or drops the packet.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_port_cfg[_valid]      16-bit listening port per channel, loaded in one cycle
//   s_axis_ip_*             IP payload stream in (no backpressure), first beat = UDP header
//   m_axis_user_*           UDP payload stream out, two cycles after the input beat
//   o_drop_cnt              saturating count of dropped packets
//
// Optional feature: define UDP_RX_LEN_CHECK_EN to drop packets whose UDP length
// disagrees with the IP payload length carried in s_axis_ip_user[55:40].
module udp_rx_mux #(
    parameter int          P_CH_NUM       = 4,
    parameter logic [15:0] P_DEFAULT_PORT = 16'h0808
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [16*P_CH_NUM-1:0]   i_port_cfg,
    input  logic                     i_port_cfg_valid,
    input  logic [63:0]              s_axis_ip_data,
    input  logic [55:0]              s_axis_ip_user,
    input  logic [7:0]               s_axis_ip_keep,
    input  logic                     s_axis_ip_last,
    input  logic                     s_axis_ip_valid,
    output logic [63:0]              m_axis_user_data,
    output logic [31:0]              m_axis_user_user,
    output logic [2:0]               m_axis_user_chan,
    output logic [7:0]               m_axis_user_keep,
    output logic                     m_axis_user_last,
    output logic                     m_axis_user_valid,
    output logic [15:0]              o_drop_cnt
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

    state_t      state_q, state_d;
    logic [15:0] tbl_q [P_CH_NUM];
    logic [2:0]  chan_q, chan_d;
    logic [31:0] user_q, user_d;
    logic [15:0] drop_q;
    logic        drop_inc;
    logic        hit;
    logic [2:0]  hit_idx;
    logic        len_ok;
    logic        pay_beat;
    logic        unused_user;
    logic        s1_valid_q;
    logic [63:0] s1_data_q;
    logic [7:0]  s1_keep_q;
    logic        s1_last_q;
    logic [31:0] s1_user_q;
    logic [2:0]  s1_chan_q;

    wire [15:0] hdr_src = s_axis_ip_data[63:48];
    wire [15:0] hdr_dst = s_axis_ip_data[47:32];
    wire [15:0] hdr_len = s_axis_ip_data[31:16];

`ifdef UDP_RX_LEN_CHECK_EN
    assign len_ok      = hdr_len == s_axis_ip_user[55:40];
    assign unused_user = ^s_axis_ip_user[39:0];
`else
    assign len_ok      = 1'b1;
    assign unused_user = ^s_axis_ip_user;
`endif

    assign pay_beat   = s_axis_ip_valid && state_q == PAYLOAD;
    assign o_drop_cnt = drop_q;

    // Scan from the top so the lowest matching index is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = P_CH_NUM - 1; k >= 0; k--)
            if (tbl_q[k] == hdr_dst) begin
                hit     = 1'b1;
                hit_idx = 3'(k);
            end
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        user_d   = user_q;
        drop_inc = 1'b0;
        if (s_axis_ip_valid)
            case (state_q)
                IDLE:
                    if (hit && len_ok && !s_axis_ip_last) begin
                        state_d = PAYLOAD;
                        chan_d  = hit_idx;
                        user_d  = {hdr_src, hdr_len - 16'd8};
                    end else begin
                        // A single-beat packet has no payload and ends right here.
                        state_d  = s_axis_ip_last ? IDLE : DROP;
                        drop_inc = 1'b1;
                    end
                default:
                    if (s_axis_ip_last) state_d = IDLE;
            endcase
    end

    // Table writes land at the clock edge, so a header in the same cycle still sees the old table.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < P_CH_NUM; k++) tbl_q[k] <= P_DEFAULT_PORT + 16'(k);
        end else if (i_port_cfg_valid) begin
            for (int k = 0; k < P_CH_NUM; k++) tbl_q[k] <= i_port_cfg[16*k +: 16];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            chan_q  <= '0;
            user_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            user_q  <= user_d;
            if (drop_inc && drop_q != 16'hffff) drop_q <= drop_q + 16'd1;
        end
    end

    // Two register stages give the fixed two-cycle input-to-output latency.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q        <= 1'b0;
            s1_data_q         <= '0;
            s1_keep_q         <= 8'hff;
            s1_last_q         <= 1'b0;
            s1_user_q         <= '0;
            s1_chan_q         <= '0;
            m_axis_user_valid <= 1'b0;
            m_axis_user_data  <= '0;
            m_axis_user_keep  <= 8'hff;
            m_axis_user_last  <= 1'b0;
            m_axis_user_user  <= '0;
            m_axis_user_chan  <= '0;
        end else begin
            s1_valid_q        <= pay_beat;
            s1_data_q         <= s_axis_ip_data;
            s1_keep_q         <= (pay_beat && s_axis_ip_last) ? s_axis_ip_keep : 8'hff;
            s1_last_q         <= pay_beat && s_axis_ip_last;
            s1_user_q         <= user_q;
            s1_chan_q         <= chan_q;
            m_axis_user_valid <= s1_valid_q;
            m_axis_user_data  <= s1_data_q;
            m_axis_user_keep  <= s1_keep_q;
            m_axis_user_last  <= s1_last_q;
            m_axis_user_user  <= s1_user_q;
            m_axis_user_chan  <= s1_chan_q;
        end
    end
endmodule
